// File: rtl/axi4_lite_reg_bank_ctrl.sv
// AXI4-Lite slave owning a bank of software-visible registers.
// Reads and writes share one access engine with round-robin arbitration on ties.
module axi4_lite_reg_bank_ctrl #(
  parameter int unsigned ADDR_BIT_WIDTH = 8,
  parameter int unsigned DATA_BIT_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_awvalid,
  output logic                               o_awready,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_awaddr,
  input  logic                               i_wvalid,
  output logic                               o_wready,
  input  logic [DATA_BIT_WIDTH-1:0]          i_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]        i_wstrb,
  output logic                               o_bvalid,
  input  logic                               i_bready,
  output logic [1:0]                         o_bresp,
  input  logic                               i_arvalid,
  output logic                               o_arready,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_araddr,
  output logic                               o_rvalid,
  input  logic                               i_rready,
  output logic [DATA_BIT_WIDTH-1:0]          o_rdata,
  output logic [1:0]                         o_rresp,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_regs
);

  localparam int unsigned STRB_W = DATA_BIT_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam logic [ADDR_BIT_WIDTH:0] NUM_REGS_EXT = (ADDR_BIT_WIDTH+1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t                            state;
  state_t                            state_nxt;
  logic                              last_grant_wr;
  logic                              wr_req;
  logic                              rd_req;
  logic                              grant_wr;
  logic                              grant_rd;
  logic [ADDR_BIT_WIDTH-1:0]         wr_idx;
  logic [ADDR_BIT_WIDTH-1:0]         rd_idx;
  logic                              wr_in_range;
  logic                              rd_in_range;
  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] regs;
  logic [DATA_BIT_WIDTH-1:0]         rd_word;

  // Word index decode; byte-offset bits are dropped.
  assign wr_idx      = i_awaddr >> OFFS_W;
  assign rd_idx      = i_araddr >> OFFS_W;
  assign wr_in_range = {1'b0, wr_idx} < NUM_REGS_EXT;
  assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_EXT;

  assign wr_req = i_awvalid & i_wvalid;
  assign rd_req = i_arvalid;

  assign o_awready = grant_wr;
  assign o_wready  = grant_wr;
  assign o_arready = grant_rd;
  assign o_regs    = regs;

  // Read mux; an out-of-range index matches nothing and yields zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == ADDR_BIT_WIDTH'(k)) begin
        rd_word = regs[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration and next state; grants only exist in IDLE.
  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      IDLE: begin
        grant_wr = wr_req & (~rd_req | ~last_grant_wr);
        grant_rd = rd_req & (~wr_req | last_grant_wr);
        if (grant_wr) begin
          state_nxt = WR_RESP;
        end else if (grant_rd) begin
          state_nxt = RD_RESP;
        end
      end
      WR_RESP: begin
        if (i_bready) begin
          state_nxt = IDLE;
        end
      end
      RD_RESP: begin
        if (i_rready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_wr <= 1'b0;
    end else if (grant_wr) begin
      last_grant_wr <= 1'b1;
    end else if (grant_rd) begin
      last_grant_wr <= 1'b0;
    end
  end

  // Register storage with per-byte strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs <= '0;
    end else if (grant_wr) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        for (int unsigned j = 0; j < STRB_W; j++) begin
          if ((wr_idx == ADDR_BIT_WIDTH'(k)) && i_wstrb[j]) begin
            regs[k*DATA_BIT_WIDTH + j*8 +: 8] <= i_wdata[j*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bvalid <= 1'b0;
      o_bresp  <= RESP_OKAY;
    end else if (grant_wr) begin
      o_bvalid <= 1'b1;
      o_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if ((state == WR_RESP) && i_bready) begin
      o_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid <= 1'b0;
      o_rresp  <= RESP_OKAY;
      o_rdata  <= '0;
    end else if (grant_rd) begin
      o_rvalid <= 1'b1;
      o_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      o_rdata  <= rd_word;
    end else if ((state == RD_RESP) && i_rready) begin
      o_rvalid <= 1'b0;
    end
  end

endmodule
